// File: rtl/cache_nway_pkg.sv
// Shared types for the N-way set-associative L1 cache.
package cache_types;

  typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} state_t;

  typedef logic [255:0] line_t;

  // A binary tree over num_ways leaves has num_ways-1 internal nodes.
  function automatic int plru_bits(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/cache_nway_if.sv
// CPU-side and physical-memory-side buses of the cache.
interface cpu_bus_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
                  input  mem_rdata, mem_resp);
  modport slave  (input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
                  output mem_rdata, mem_resp);
endinterface

interface pmem_bus_if;
  import cache_types::*;
  logic [31:0] pmem_address;
  line_t       pmem_rdata;
  line_t       pmem_wdata;
  logic        pmem_read;
  logic        pmem_write;
  logic        pmem_resp;

  modport master (output pmem_address, pmem_wdata, pmem_read, pmem_write,
                  input  pmem_rdata, pmem_resp);
  modport slave  (input  pmem_address, pmem_wdata, pmem_read, pmem_write,
                  output pmem_rdata, pmem_resp);
endinterface

// File: rtl/cache_nway_plru_tree.sv
// Tree pseudo-LRU: victim walk and access update. Node n has children 2n+1 (low) and 2n+2 (high).
module plru_tree
  import cache_types::*;
#(
  parameter  int num_ways = 4,
  localparam int WW       = $clog2(num_ways),
  localparam int PB       = plru_bits(num_ways)
) (
  input  logic [PB-1:0] bits,
  input  logic [WW-1:0] acc_way,
  output logic [WW-1:0] victim,
  output logic [PB-1:0] next_bits
);

  // A node bit of 0 sends the victim walk to the lower-index subtree.
  always_comb begin
    int   node;
    logic b;
    victim = '0;
    node   = 0;
    for (int l = 0; l < WW; l++) begin
      b = 1'b0;
      for (int n = 0; n < PB; n++)
        if (n == node) b = bits[n];
      victim[WW-1-l] = b;
      node = 2 * node + 1 + (b ? 1 : 0);
    end
  end

  // Each node on the accessed path is pointed at the sibling subtree.
  always_comb begin
    int   node;
    logic d;
    next_bits = bits;
    node      = 0;
    for (int l = 0; l < WW; l++) begin
      d = acc_way[WW-1-l];
      for (int n = 0; n < PB; n++)
        if (n == node) next_bits[n] = ~d;
      node = 2 * node + 1 + (d ? 1 : 0);
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back / write-allocate L1 cache with tree PLRU and hit/miss counters.
module cache_nway
  import cache_types::*;
#(
  parameter int s_offset  = 5,
  parameter int s_index   = 3,
  parameter int s_tag     = 32 - s_offset - s_index,
  parameter int num_ways  = 4,
  parameter int cnt_width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_bus_if.slave             cpu,
  pmem_bus_if.master           pmem,
  output logic [cnt_width-1:0] hit_count,
  output logic [cnt_width-1:0] miss_count
);

  localparam int num_sets = 2 ** s_index;
  localparam int WW       = $clog2(num_ways);
  localparam int PB       = plru_bits(num_ways);

  line_t               data_arr [num_sets][num_ways];
  logic [s_tag-1:0]    tag_arr  [num_sets][num_ways];
  logic [num_ways-1:0] valid    [num_sets];
  logic [num_ways-1:0] dirty    [num_sets];
  logic [PB-1:0]       plru     [num_sets];

  state_t                state, next_state;
  logic [WW-1:0]         victim_q;
  logic [31-s_offset:0]  line_q;

  logic                  req, is_write, hit, has_free, do_hit, do_miss;
  logic [s_index-1:0]    idx, aidx;
  logic [s_tag-1:0]      tag;
  logic [2:0]            sel;
  logic [WW-1:0]         hit_way, free_way, plru_victim, victim;
  logic [PB-1:0]         plru_next;
  logic [31:0]           hit_word, merged;
  logic                  unused;

  assign req      = cpu.mem_read | cpu.mem_write;
  assign is_write = cpu.mem_write;
  assign idx      = cpu.mem_address[s_offset +: s_index];
  assign tag      = cpu.mem_address[31 -: s_tag];
  assign sel      = cpu.mem_address[4:2];
  assign aidx     = line_q[s_index-1:0];
  assign unused   = ^cpu.mem_address[1:0];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < num_ways; w++)
      if (valid[idx][w] && tag_arr[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
  end

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    has_free = 1'b0;
    free_way = '0;
    for (int w = num_ways - 1; w >= 0; w--)
      if (!valid[idx][w]) begin
        has_free = 1'b1;
        free_way = WW'(w);
      end
  end

  plru_tree #(.num_ways(num_ways)) u_plru (
    .bits      (plru[idx]),
    .acc_way   (hit_way),
    .victim    (plru_victim),
    .next_bits (plru_next)
  );

  assign victim   = has_free ? free_way : plru_victim;
  assign hit_word = data_arr[idx][hit_way][{sel, 5'b0} +: 32];
  assign do_hit   = (state == CHECK) && req && hit;
  assign do_miss  = (state == CHECK) && req && !hit;

  always_comb begin
    for (int b = 0; b < 4; b++)
      merged[b*8 +: 8] = cpu.mem_byte_enable[b] ? cpu.mem_wdata[b*8 +: 8] : hit_word[b*8 +: 8];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= CHECK;
    else     state <= next_state;

  always_comb begin
    next_state = state;
    case (state)
      CHECK:     if (do_miss)
                   next_state = (valid[idx][victim] && dirty[idx][victim]) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (pmem.pmem_resp) next_state = ALLOCATE;
      ALLOCATE:  if (pmem.pmem_resp) next_state = CHECK;
      default:   next_state = CHECK;
    endcase
  end

  always_comb begin
    cpu.mem_resp      = 1'b0;
    cpu.mem_rdata     = hit_word;
    pmem.pmem_read    = 1'b0;
    pmem.pmem_write   = 1'b0;
    pmem.pmem_address = '0;
    pmem.pmem_wdata   = data_arr[aidx][victim_q];
    case (state)
      CHECK:     cpu.mem_resp = req && hit;
      WRITEBACK: begin
        pmem.pmem_write   = 1'b1;
        pmem.pmem_address = {tag_arr[aidx][victim_q], aidx, {s_offset{1'b0}}};
      end
      ALLOCATE:  begin
        pmem.pmem_read    = 1'b1;
        pmem.pmem_address = {line_q, {s_offset{1'b0}}};
      end
      default: ;
    endcase
  end

  // Line address is captured with the victim so a dropped request cannot disturb the fill.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int s = 0; s < num_sets; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        plru[s]  <= '0;
      end
      victim_q   <= '0;
      line_q     <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (do_hit) begin
        plru[idx] <= plru_next;
        if (is_write) dirty[idx][hit_way] <= 1'b1;
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
      end
      if (do_miss) begin
        victim_q <= victim;
        line_q   <= cpu.mem_address[31:s_offset];
        if (miss_count != '1) miss_count <= miss_count + 1'b1;
      end
      if (state == WRITEBACK && pmem.pmem_resp)
        dirty[aidx][victim_q] <= 1'b0;
      if (state == ALLOCATE && pmem.pmem_resp) begin
        valid[aidx][victim_q] <= 1'b1;
        dirty[aidx][victim_q] <= 1'b0;
      end
    end

  always_ff @(posedge clk) begin
    if (do_hit && is_write)
      data_arr[idx][hit_way][{sel, 5'b0} +: 32] <= merged;
    if (state == ALLOCATE && pmem.pmem_resp) begin
      data_arr[aidx][victim_q] <= pmem.pmem_rdata;
      tag_arr[aidx][victim_q]  <= line_q[s_index +: s_tag];
    end
  end

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench: flat-memory reference model, 3-cycle physical memory responder, literal pins.
module tb_cache_nway;
  import cache_types::*;

  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] hit_count, miss_count;

  cpu_bus_if  cpu();
  pmem_bus_if pmem();

  cache_nway #(.cnt_width(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (cpu.slave),
    .pmem       (pmem.master),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit [31:0]   ref_mem [int unsigned];
  line_t       backing [int unsigned];
  logic [31:0] rd_q [$];
  logic [31:0] wr_q [$];
  line_t       wd_q [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w == 0) ? 32'h1122_3344 : {16'h5A5A, w[15:0]};
  endfunction

  function automatic line_t backing_line(input int unsigned la);
    line_t l;
    if (backing.exists(la)) return backing[la];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la * 8 + i);
    return l;
  endfunction

  // CPU-visible memory: latest CPU write, else what physical memory holds.
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int unsigned wa;
    line_t l;
    wa = a >> 2;
    if (ref_mem.exists(wa)) return ref_mem[wa];
    l = backing_line(wa >> 3);
    return l[(wa % 8) * 32 +: 32];
  endfunction

  initial begin
    int cnt;
    cnt = 0;
    pmem.pmem_resp  = 1'b0;
    pmem.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem.pmem_resp) begin
        pmem.pmem_resp = 1'b0;
        cnt = 0;
      end else if (!rst && (pmem.pmem_read || pmem.pmem_write)) begin
        cnt++;
        if (cnt == 3) begin
          if (pmem.pmem_write) begin
            wr_q.push_back(pmem.pmem_address);
            wd_q.push_back(pmem.pmem_wdata);
            for (int i = 0; i < 8; i++)
              check("wb_word", pmem.pmem_wdata[i*32 +: 32], ref_word(pmem.pmem_address + 32'(i * 4)));
            backing[pmem.pmem_address >> 5] = pmem.pmem_wdata;
          end else begin
            rd_q.push_back(pmem.pmem_address);
            pmem.pmem_rdata = backing_line(pmem.pmem_address >> 5);
          end
          pmem.pmem_resp = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("pmem_excl", {pmem.pmem_read, pmem.pmem_write} == 2'b11, 1'b0);
        if (cpu.mem_resp && cpu.mem_read && !cpu.mem_write)
          check("rdata", cpu.mem_rdata, ref_word(cpu.mem_address));
      end
    end
  end

  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output int cyc);
    logic [31:0] w;
    @(posedge clk); #1;
    cpu.mem_read        = !wr;
    cpu.mem_write       = wr;
    cpu.mem_address     = a;
    cpu.mem_wdata       = d;
    cpu.mem_byte_enable = be;
    cyc = 0;
    rd  = 'x;
    @(negedge clk);
    while (!cpu.mem_resp && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    if (!cpu.mem_resp) begin
      total++;
      bad++;
      $display("FAIL resp_timeout: addr %0h got no mem_resp within 200 cycles", a);
    end else begin
      rd = cpu.mem_rdata;
      if (wr) begin
        w = ref_word(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
        ref_mem[a >> 2] = w;
      end
    end
    @(posedge clk); #1;
    cpu.mem_read  = 1'b0;
    cpu.mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int cyc, n;
    cpu.mem_read        = 1'b0;
    cpu.mem_write       = 1'b0;
    cpu.mem_address     = '0;
    cpu.mem_wdata       = '0;
    cpu.mem_byte_enable = '0;
    #12;
    check("rst_mem_resp",   cpu.mem_resp,    1'b0);
    check("rst_pmem_read",  pmem.pmem_read,  1'b0);
    check("rst_pmem_write", pmem.pmem_write, 1'b0);
    check("rst_hit_count",  hit_count,  '0);
    check("rst_miss_count", miss_count, '0);
    @(negedge clk); rst = 1'b0;

    access(0, 32'h0000_0000, 0, 0, rd, cyc);
    check("cold_rdata", rd, 32'h1122_3344);
    check("cold_latency", cyc, 4);
    check("cold_fill_addr", rd_q[0], 32'h0000_0000);
    check("cold_hits", hit_count, 5'd1);
    check("cold_misses", miss_count, 5'd1);

    access(1, 32'h0000_0004, 32'hDEAD_BEEF, 4'b0011, rd, cyc);
    check("wr_hit_latency", cyc, 0);
    access(0, 32'h0000_0004, 0, 0, rd, cyc);
    check("merge_rdata", rd, 32'h5A5A_BEEF);

    access(0, 32'h0000_0100, 0, 0, rd, cyc);
    access(1, 32'h0000_0200, 32'hCAFE_F00D, 4'b1111, rd, cyc);
    check("wr_miss_latency", cyc, 4);
    access(0, 32'h0000_0300, 0, 0, rd, cyc);
    access(0, 32'h0000_0000, 0, 0, rd, cyc);
    check("reread0_hit", cyc, 0);
    check("no_wb_yet", wr_q.size(), 0);

    access(0, 32'h0000_0400, 0, 0, rd, cyc);
    check("evict_latency", cyc, 8);
    check("wb_count", wr_q.size(), 1);
    if (wr_q.size() > 0) begin
      check("wb_addr", wr_q[0], 32'h0000_0200);
      check("wb_word0", wd_q[0][31:0], 32'hCAFE_F00D);
    end
    check("fill_after_wb", rd_q[rd_q.size()-1], 32'h0000_0400);
    check("evict_rdata", rd, 32'h5A5A_0100);

    access(0, 32'h0000_0000, 0, 0, rd, cyc);
    check("way0_survives", cyc, 0);
    access(0, 32'h0000_0200, 0, 0, rd, cyc);
    check("refetch_rdata", rd, 32'hCAFE_F00D);
    check("refetch_clean", wr_q.size(), 1);
    check("mid_hits", hit_count, 5'd10);
    check("mid_misses", miss_count, 5'd6);

    // Reset while the fill for 0x800 is outstanding.
    @(posedge clk); #1;
    cpu.mem_read    = 1'b1;
    cpu.mem_address = 32'h0000_0800;
    n = 0;
    @(negedge clk);
    while (!pmem.pmem_read && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("pre_rst_pmem_read", pmem.pmem_read, 1'b1);
    n = rd_q.size();
    #1 rst = 1'b1;
    #1;
    check("async_pmem_read", pmem.pmem_read, 1'b0);
    check("async_pmem_write", pmem.pmem_write, 1'b0);
    cpu.mem_read = 1'b0;
    ref_mem.delete();
    @(negedge clk);
    check("rst2_hits", hit_count, '0);
    check("rst2_misses", miss_count, '0);
    rst = 1'b0;

    access(0, 32'h0000_0800, 0, 0, rd, cyc);
    check("post_rst_miss", cyc, 4);
    check("post_rst_fill", rd_q.size(), n + 1);
    check("post_rst_rdata", rd, 32'h5A5A_0200);

    for (int i = 0; i < 29; i++) access(0, 32'h0000_0800, 0, 0, rd, cyc);
    check("hits_30", hit_count, 5'd30);
    access(0, 32'h0000_0800, 0, 0, rd, cyc);
    check("hits_sat", hit_count, 5'h1F);
    for (int i = 0; i < 3; i++) access(0, 32'h0000_0800, 0, 0, rd, cyc);
    check("hits_stay_sat", hit_count, 5'h1F);
    check("sat_misses", miss_count, 5'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
